// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: the instruction-memory req/gnt/rvalid channel and the decode valid/ready channel.
// The master modport is the fetch stage; the slave modport is the memory/decode side.
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req_op;
  logic [ADDR_W-1:0] instr_addr_op;
  logic              instr_gnt_ip;
  logic              instr_rvalid_ip;
  logic [DATA_W-1:0] instr_rdata_ip;
  logic              instr_valid_op;
  logic [DATA_W-1:0] instr_data_op;
  logic [ADDR_W-1:0] instr_pc_addr_op;
  logic              id_ready_ip;

  modport master (
    output instr_req_op, instr_addr_op, instr_valid_op, instr_data_op, instr_pc_addr_op,
    input  instr_gnt_ip, instr_rvalid_ip, instr_rdata_ip, id_ready_ip
  );

  modport slave (
    input  instr_req_op, instr_addr_op, instr_valid_op, instr_data_op, instr_pc_addr_op,
    output instr_gnt_ip, instr_rvalid_ip, instr_rdata_ip, id_ready_ip
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: pipelined memory requests, PC-tagged prefetch queue, redirect flush/drain.
// Optional IF_MISALIGN_CHK_EN: flags misaligned redirect targets on instr_misalign_op and blocks issue.
module if_prefetch_stage #(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_valid_ip,
  input  logic [ADDR_W-1:0]    redirect_addr_ip,
  if_prefetch_stage_if.master  bus,
  output logic                 fetch_busy_op
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic                 instr_misalign_op
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0]  OUT_ONE = OUT_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(4);

  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] redirect_addr;
  logic              credit_ok, req, grant, valid, push, pop;

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_addr     = redirect_addr_ip;
  assign instr_misalign_op = misalign_q;
`else
  assign redirect_addr     = redirect_addr_ip & ~ADDR_W'(3);
`endif

  // Live in-flight requests each own a queue slot, so a returning word never finds the queue full.
  assign credit_ok = (int'(count_q) + int'(outst_q) - int'(discard_q)) < FIFO_DEPTH;
  assign req   = !reset && !redirect_valid_ip && !misalign_q
                 && (int'(outst_q) < MAX_OUTSTANDING) && credit_ok;
  assign grant = req && bus.instr_gnt_ip;
  assign valid = (count_q != '0) && !redirect_valid_ip;
  assign pop   = valid && bus.id_ready_ip;
  assign push  = !redirect_valid_ip && bus.instr_rvalid_ip && (state_q == ST_RUN);

  assign bus.instr_req_op     = req;
  assign bus.instr_addr_op    = fetch_pc_q;
  assign bus.instr_valid_op   = valid;
  assign bus.instr_data_op    = data_mem_q[rd_ptr_q];
  assign bus.instr_pc_addr_op = pc_mem_q[rd_ptr_q];
  assign fetch_busy_op        = (outst_q != '0) || (discard_q != '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    misalign_d = misalign_q;

    if (grant && !bus.instr_rvalid_ip) begin
      outst_d = outst_q + OUT_ONE;
    end else if (!grant && bus.instr_rvalid_ip) begin
      outst_d = outst_q - OUT_ONE;
    end
    if (grant) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end

    if (redirect_valid_ip) begin
      // No grant is possible here, so outst_d is already outstanding minus this cycle's response.
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outst_d;
      state_d    = (outst_d != '0) ? ST_DRAIN : ST_RUN;
`ifdef IF_MISALIGN_CHK_EN
      misalign_d = |redirect_addr_ip[1:0];
`endif
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        resp_pc_d = resp_pc_q + PC_INC;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_d = count_q - CNT_ONE;
      end
      case (state_q)
        ST_DRAIN: begin
          if (bus.instr_rvalid_ip) begin
            discard_d = discard_q - OUT_ONE;
            if (discard_q == OUT_ONE) begin
              state_d = ST_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  // Entries are cleared on reset so the head outputs read zero until the first push.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      data_mem_q[wr_ptr_q] <= bus.instr_rdata_ip;
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage: in-order memory model plus a transaction-level model of
// the expected fetch address, delivered PC/data stream, issue credit and busy flag.
module tb_if_prefetch_stage;
  localparam int              AW    = 32;
  localparam int              DW    = 32;
  localparam int              DEPTH = 4;
  localparam int              MAXO  = 2;
  localparam logic [AW-1:0]   RPC   = 32'h0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          busy;
  logic          misalign;

  if_prefetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_prefetch_stage #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_valid_ip (redirect_valid),
    .redirect_addr_ip  (redirect_addr),
    .bus               (bus.master),
    .fetch_busy_op     (busy)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .instr_misalign_op (misalign)
`endif
  );

`ifndef IF_MISALIGN_CHK_EN
  assign misalign = 1'b0;
`endif

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory side: requests accepted but not yet answered, in order.
  logic [AW-1:0] pend_addr[$];
  logic [AW-1:0] pend_exp[$];
  logic          pend_live[$];
  int            pend_due[$];
  // Decode side: words that should currently sit in the prefetch queue.
  logic [AW-1:0] exp_pc[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] m_fetch_pc;
  logic          m_mis;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    pend_addr.delete(); pend_exp.delete(); pend_live.delete(); pend_due.delete();
    exp_pc.delete(); exp_data.delete();
    m_fetch_pc = RPC;
    m_mis      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    bus.instr_gnt_ip = 1'b0;
    bus.instr_rvalid_ip = 1'b0;
    bus.instr_rdata_ip = '0;
    bus.id_ready_ip = 1'b0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_req", bus.instr_req_op, 1'b0);
    check_eq("rst_addr", bus.instr_addr_op, RPC);
    check_eq("rst_valid", bus.instr_valid_op, 1'b0);
    check_eq("rst_data", bus.instr_data_op, '0);
    check_eq("rst_pc", bus.instr_pc_addr_op, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_misalign", misalign, 1'b0);
    $display("cycle=%0d reset", cyc);
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model to the next rising edge.
  task automatic step(input int pg, input int pv, input int prdy, input int pred, input int maxlat,
                      input bit force_redir, input logic [AW-1:0] faddr);
    int            live;
    bit            exp_req, exp_valid, grant, popped, rv;
    logic [AW-1:0] a;
    redirect_valid = force_redir || ($urandom_range(99) < pred);
    if (force_redir) begin
      a = faddr;
    end else if ($urandom_range(7) == 0) begin
      a = 32'hFFFF_FFF8;
    end else begin
      a = 32'($urandom_range(1023)) * 4;
      if ($urandom_range(3) == 0) a = a + 32'($urandom_range(1, 3));
    end
    redirect_addr = a;
    bus.instr_gnt_ip = ($urandom_range(99) < pg);
    rv = (pend_addr.size() != 0) && (pend_due[0] <= cyc) && ($urandom_range(99) < pv);
    bus.instr_rvalid_ip = rv;
    bus.instr_rdata_ip = rv ? mem_word(pend_addr[0]) : $urandom;
    bus.id_ready_ip = ($urandom_range(99) < prdy);

    @(negedge clock);
    live = 0;
    foreach (pend_live[i]) if (pend_live[i]) live++;
    exp_req = !redirect_valid && (pend_addr.size() < MAXO)
              && (exp_pc.size() + live < DEPTH) && !m_mis;
    check_eq("req", bus.instr_req_op, exp_req);
    if (exp_req) check_eq("addr", bus.instr_addr_op, m_fetch_pc);
    exp_valid = (exp_pc.size() != 0) && !redirect_valid;
    check_eq("valid", bus.instr_valid_op, exp_valid);
    if (exp_valid) begin
      check_eq("head_pc", bus.instr_pc_addr_op, exp_pc[0]);
      check_eq("head_data", bus.instr_data_op, exp_data[0]);
    end
    check_eq("busy", busy, pend_addr.size() != 0);
    check_eq("misalign", misalign, m_mis);

    grant  = bus.instr_req_op && bus.instr_gnt_ip;
    popped = exp_valid && bus.id_ready_ip;
    $display("cycle=%0d redir=%0b req=%0b gnt=%0b rvalid=%0b valid=%0b pc=%08h rdy=%0b busy=%0b",
             cyc, redirect_valid, bus.instr_req_op, bus.instr_gnt_ip, rv,
             bus.instr_valid_op, bus.instr_pc_addr_op, bus.id_ready_ip, busy);

    if (redirect_valid) begin
      if (rv) begin
        void'(pend_addr.pop_front()); void'(pend_exp.pop_front());
        void'(pend_live.pop_front()); void'(pend_due.pop_front());
      end
      foreach (pend_live[i]) pend_live[i] = 1'b0;
      exp_pc.delete(); exp_data.delete();
`ifdef IF_MISALIGN_CHK_EN
      m_fetch_pc = a;
      m_mis      = (a[1:0] != 2'b00);
`else
      m_fetch_pc = a & ~32'h3;
      m_mis      = 1'b0;
`endif
    end else begin
      if (popped) begin
        void'(exp_pc.pop_front()); void'(exp_data.pop_front());
      end
      if (rv) begin
        logic [AW-1:0] e;
        logic          l;
        e = pend_exp.pop_front();
        l = pend_live.pop_front();
        void'(pend_addr.pop_front()); void'(pend_due.pop_front());
        if (l) begin
          exp_pc.push_back(e);
          exp_data.push_back(mem_word(e));
        end
      end
      if (grant) begin
        pend_addr.push_back(bus.instr_addr_op);
        pend_exp.push_back(m_fetch_pc);
        pend_live.push_back(1'b1);
        pend_due.push_back(cyc + $urandom_range(1, maxlat));
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int pg, input int pv, input int prdy, input int pred,
                     input int maxlat);
    for (int i = 0; i < n; i++) step(pg, pv, prdy, pred, maxlat, 1'b0, '0);
  endtask

  initial begin
    bus.instr_gnt_ip = 1'b0;
    bus.instr_rvalid_ip = 1'b0;
    bus.instr_rdata_ip = '0;
    bus.id_ready_ip = 1'b0;
    do_reset();
    run(40, 100, 100, 100, 0, 1);    // streaming, 1-cycle memory
    run(20, 100, 100, 0, 0, 1);      // decode stalled: queue fills, issue stops
    run(20, 100, 100, 100, 0, 1);    // release
    run(6, 0, 100, 100, 0, 1);       // grant withheld
    run(10, 100, 100, 100, 0, 1);
    run(3, 100, 0, 100, 0, 1);       // build up outstanding requests
    step(100, 0, 100, 0, 1, 1'b1, 32'h100);
    run(20, 100, 100, 100, 0, 2);
    step(100, 100, 100, 0, 1, 1'b1, 32'h102);
    run(10, 100, 100, 100, 0, 1);
    step(100, 100, 100, 0, 1, 1'b1, 32'h200);
    run(20, 100, 100, 100, 0, 1);
    run(1200, 70, 70, 70, 4, 3);
    run(400, 90, 90, 30, 15, 2);
    do_reset();
    run(600, 60, 80, 85, 6, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
